// File: rtl/bcd_pkg.sv
// Shared definitions for the binary-to-BCD converter: FSM states, display
// limits and the BCD digit type.
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   typedef logic [3:0] bcd_digit_t;

   // Largest value the four-digit display can show.
   localparam int MAX_DEC = 9999;

   // Digit code the seven-segment decoder renders as a dash.
   localparam bcd_digit_t DIGIT_DASH = 4'hF;

   // Saturated digit used when the dash pattern is not wanted.
   localparam bcd_digit_t DIGIT_NINE = 4'd9;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble correction cell: a BCD nibble of 5 or more gets +3 so that the
// following left shift carries correctly into the next decimal digit.
module bcd_add3
   import bcd_pkg::*;
(
   input  bcd_digit_t nib_in,
   output bcd_digit_t nib_out
);

   assign nib_out = (nib_in >= 4'd5) ? nib_in + 4'd3 : nib_in;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter feeding the four-digit
// seven-segment multiplexer. One input bit is consumed per clock; the
// registered digits hold between conversions.
// Build option: define BIN2BCD_OVF_DASH_EN to show out-of-range values as
// four dashes instead of saturating to 9999.
module bin2bcd_seq
   import bcd_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int MAX_DEC = bcd_pkg::MAX_DEC
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_value,
   output logic [3:0]       dig0,
   output logic [3:0]       dig1,
   output logic [3:0]       dig2,
   output logic [3:0]       dig3,
   output logic             out_valid,
   output logic             overflow
);

`ifdef BIN2BCD_OVF_DASH_EN
   localparam bcd_digit_t OVF_DIGIT = DIGIT_DASH;
`else
   localparam bcd_digit_t OVF_DIGIT = DIGIT_NINE;
`endif

   localparam logic [31:0] MAX_DEC_U  = MAX_DEC;
   localparam logic [4:0]  LAST_COUNT = 5'(WIDTH - 1);

   state_t             state_reg, state_next;
   logic [WIDTH-1:0]   shift_reg;
   logic [15:0]        scratch_reg;
   logic [15:0]        scratch_adj;
   logic [4:0]         count_reg;
   logic               pend_reg;
   logic               hold_reg;
   logic [15:0]        digits_reg;
   logic               out_valid_reg;
   logic               overflow_reg;

   logic               in_ovf;
   logic               accept;
   logic               last_shift;
   logic               commit;

   assign in_ovf     = (32'(in_value) > MAX_DEC_U);
   assign last_shift = (count_reg == LAST_COUNT);

   // Four correction cells work on the scratch nibbles in parallel.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_add3
         bcd_add3 u_add3 (
            .nib_in  (scratch_reg[gi*4 +: 4]),
            .nib_out (scratch_adj[gi*4 +: 4])
         );
      end
   endgenerate

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   // Next-state logic. An overflow result dwells two cycles in DONE so its
   // pulse arrives two edges after acceptance.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (in_valid) state_next = in_ovf ? DONE : SHIFT;
         SHIFT:   if (last_shift) state_next = DONE;
         DONE:    if (!(pend_reg && !hold_reg)) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // FSM outputs: handshake and the digit commit strobe.
   always_comb begin
      in_ready = (state_reg == IDLE);
      accept   = in_ready && in_valid;
      commit   = (state_reg == DONE) && !(pend_reg && !hold_reg);
   end

   // Shift datapath and result registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         shift_reg     <= '0;
         scratch_reg   <= '0;
         count_reg     <= '0;
         pend_reg      <= 1'b0;
         hold_reg      <= 1'b0;
         digits_reg    <= '0;
         out_valid_reg <= 1'b0;
         overflow_reg  <= 1'b0;
      end else begin
         out_valid_reg <= 1'b0;
         if (accept) begin
            shift_reg   <= in_value;
            scratch_reg <= '0;
            count_reg   <= '0;
            pend_reg    <= in_ovf;
            hold_reg    <= 1'b0;
         end else if (state_reg == SHIFT) begin
            {scratch_reg, shift_reg} <= {scratch_adj, shift_reg} << 1;
            count_reg                <= count_reg + 5'd1;
         end else if (state_reg == DONE && !commit) begin
            hold_reg <= 1'b1;
         end
         if (commit) begin
            digits_reg    <= pend_reg ? {4{OVF_DIGIT}} : scratch_reg;
            overflow_reg  <= pend_reg;
            out_valid_reg <= 1'b1;
         end
      end
   end

   assign dig0      = digits_reg[3:0];
   assign dig1      = digits_reg[7:4];
   assign dig2      = digits_reg[11:8];
   assign dig3      = digits_reg[15:12];
   assign out_valid = out_valid_reg;
   assign overflow  = overflow_reg;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed vector table, hand-written
// multi-cycle sequences and a strided sweep against a decimal reference.
module tb_bin2bcd_seq;

`ifdef BIN2BCD_OVF_DASH_EN
   localparam logic [15:0] OVF_DIGS = 16'hFFFF;
`else
   localparam logic [15:0] OVF_DIGS = 16'h9999;
`endif

   localparam int LAT_NORM = 17;
   localparam int LAT_OVF  = 2;

   logic        clock;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_value;
   logic [3:0]  dig0, dig1, dig2, dig3;
   logic        out_valid;
   logic        overflow;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   int          pulse_cyc[$];
   logic [15:0] pulse_dig[$];
   logic        pulse_ovf[$];

   logic [15:0] last_digs;
   logic        prev_ov;

   typedef struct {
      logic [15:0] val;
      logic [15:0] exp_digs;
      logic        exp_ovf;
      int          exp_lat;
   } vec_t;

   vec_t vecs[12];

   bin2bcd_seq #(.WIDTH(16)) dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_value  (in_value),
      .dig0      (dig0),
      .dig1      (dig1),
      .dig2      (dig2),
      .dig3      (dig3),
      .out_valid (out_valid),
      .overflow  (overflow)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Pulse logger plus pulse-width and digit-hold checks.
   always @(negedge clock) begin
      if (reset) begin
         prev_ov = 1'b0;
      end else if (out_valid) begin
         chk("out_valid_width", {31'd0, prev_ov}, 32'd0);
         pulse_cyc.push_back(cyc);
         pulse_dig.push_back({dig3, dig2, dig1, dig0});
         pulse_ovf.push_back(overflow);
         prev_ov = 1'b1;
      end else begin
         chk("digits_held", {16'd0, dig3, dig2, dig1, dig0}, {16'd0, last_digs});
         prev_ov = 1'b0;
      end
      last_digs = {dig3, dig2, dig1, dig0};
   end

   task automatic wait_cycles(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   // Waits for the pulse count to exceed n, bounded.
   task automatic wait_pulse(input int n, input int budget, output bit ok);
      int waited = 0;
      while (pulse_cyc.size() <= n && waited < budget) begin
         @(posedge clock);
         #1;
         waited++;
      end
      ok = (pulse_cyc.size() > n);
   endtask

   task automatic do_conv(input string name, input logic [15:0] v, input logic [15:0] exp_digs,
                          input logic exp_ovf, input int exp_lat);
      int n, kc, waited;
      bit ok;
      waited = 0;
      while (!in_ready && waited < 40) begin
         @(posedge clock);
         #1;
         waited++;
      end
      chk({name, "_ready"}, {31'd0, in_ready}, 32'd1);
      n        = pulse_cyc.size();
      in_valid = 1'b1;
      in_value = v;
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      kc       = cyc;
      wait_pulse(n, 40, ok);
      if (!ok) begin
         chk({name, "_timeout"}, 32'd0, 32'd1);
      end else begin
         chk({name, "_latency"}, 32'(pulse_cyc[n] - kc), 32'(exp_lat));
         chk({name, "_digits"}, {16'd0, pulse_dig[n]}, {16'd0, exp_digs});
         chk({name, "_overflow"}, {31'd0, pulse_ovf[n]}, {31'd0, exp_ovf});
         $display("conv %s in=%0d digits=%h ovf=%0b latency=%0d", name, v, pulse_dig[n],
                  pulse_ovf[n], pulse_cyc[n] - kc);
      end
   endtask

   function automatic logic [15:0] ref_bcd(input int v);
      return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int  n, kc;
      bit  ok;

      vecs[0]  = '{16'd1234,  16'h1234, 1'b0, LAT_NORM};
      vecs[1]  = '{16'd10000, OVF_DIGS, 1'b1, LAT_OVF};
      vecs[2]  = '{16'd42,    16'h0042, 1'b0, LAT_NORM};
      vecs[3]  = '{16'd65535, OVF_DIGS, 1'b1, LAT_OVF};
      vecs[4]  = '{16'd9999,  16'h9999, 1'b0, LAT_NORM};
      vecs[5]  = '{16'd1,     16'h0001, 1'b0, LAT_NORM};
      vecs[6]  = '{16'd10,    16'h0010, 1'b0, LAT_NORM};
      vecs[7]  = '{16'd99,    16'h0099, 1'b0, LAT_NORM};
      vecs[8]  = '{16'd100,   16'h0100, 1'b0, LAT_NORM};
      vecs[9]  = '{16'd1000,  16'h1000, 1'b0, LAT_NORM};
      vecs[10] = '{16'd8191,  16'h8191, 1'b0, LAT_NORM};
      vecs[11] = '{16'd0,     16'h0000, 1'b0, LAT_NORM};

      reset     = 1'b1;
      in_valid  = 1'b0;
      in_value  = '0;
      last_digs = '0;
      prev_ov   = 1'b0;
      wait_cycles(3);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_digits", {16'd0, dig3, dig2, dig1, dig0}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_overflow", {31'd0, overflow}, 32'd0);
      reset = 1'b0;
      wait_cycles(2);

      for (int i = 0; i < 12; i++)
         do_conv($sformatf("vec%0d", i), vecs[i].val, vecs[i].exp_digs, vecs[i].exp_ovf,
                 vecs[i].exp_lat);

      // Back-to-back: 0 then 9999, second request held high while busy.
      n        = pulse_cyc.size();
      in_valid = 1'b1;
      in_value = 16'd0;
      @(posedge clock);
      #1;
      kc       = cyc;
      in_value = 16'd9999;
      wait_pulse(n, 40, ok);
      in_valid = 1'b0;
      chk("b2b_second_accepted", {31'd0, in_ready}, 32'd0);
      wait_pulse(n + 1, 40, ok);
      if (!ok) begin
         chk("b2b_timeout", 32'd0, 32'd1);
      end else begin
         chk("b2b_first_latency", 32'(pulse_cyc[n] - kc), 32'(LAT_NORM));
         chk("b2b_first_digits", {16'd0, pulse_dig[n]}, 32'h0000);
         chk("b2b_second_digits", {16'd0, pulse_dig[n+1]}, 32'h9999);
         chk("b2b_spacing", 32'(pulse_cyc[n+1] - pulse_cyc[n]), 32'd18);
         $display("conv b2b first=%h second=%h spacing=%0d", pulse_dig[n], pulse_dig[n+1],
                  pulse_cyc[n+1] - pulse_cyc[n]);
      end
      wait_cycles(1);

      // Request of 7777 during SHIFT of 5 must be ignored.
      n        = pulse_cyc.size();
      in_valid = 1'b1;
      in_value = 16'd5;
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      kc       = cyc;
      wait_cycles(4);
      in_valid = 1'b1;
      in_value = 16'd7777;
      wait_cycles(1);
      in_valid = 1'b0;
      wait_pulse(n, 40, ok);
      if (!ok) begin
         chk("busy_timeout", 32'd0, 32'd1);
      end else begin
         chk("busy_latency", 32'(pulse_cyc[n] - kc), 32'(LAT_NORM));
         chk("busy_digits", {16'd0, pulse_dig[n]}, 32'h0005);
         $display("conv busy-ignore in=5 digits=%h", pulse_dig[n]);
      end
      wait_cycles(25);
      chk("busy_no_extra_pulse", 32'(pulse_cyc.size()), 32'(n + 1));

      // Reset mid-SHIFT while converting 4321.
      n        = pulse_cyc.size();
      in_valid = 1'b1;
      in_value = 16'd4321;
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      wait_cycles(6);
      #2;
      reset = 1'b1;
      #1;
      chk("midrst_digits", {16'd0, dig3, dig2, dig1, dig0}, 32'd0);
      chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      wait_cycles(2);
      reset = 1'b0;
      wait_cycles(25);
      chk("midrst_no_pulse", 32'(pulse_cyc.size()), 32'(n));
      $display("conv reset-abort in=4321 pulses_after_release=%0d", pulse_cyc.size() - n);
      do_conv("after_rst", 16'd4321, 16'h4321, 1'b0, LAT_NORM);

      // Strided sweep against the decimal reference.
      for (int v = 0; v <= 9999; v += 53)
         do_conv($sformatf("sweep%0d", v), 16'(v), ref_bcd(v), 1'b0, LAT_NORM);

      wait_cycles(3);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
